// File: rtl/wts_channel_amp.sv
// wts_channel_amp: three-stage, time-multiplexed channel amplifier.
// S0 captures the sample and picks the applied volume (optionally ramped),
// S1 applies the envelope gain and S2 applies the channel volume. Both gain
// stages round toward zero, so gain never adds magnitude to a sample.
module wts_channel_amp #(
  parameter  int SW      = 8,
  parameter  int EW      = 8,
  parameter  int VW      = 4,
  parameter  int NCH     = 5,
  parameter  int RAMP_EN = 1,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  in_valid,
  input  logic [CHW-1:0]        in_ch,
  input  logic [SW-1:0]         in_wave,
  input  logic [EW:0]           in_envelope,
  input  logic [NCH*VW-1:0]     reg_volume,
  output logic                  out_valid,
  output logic [CHW-1:0]        out_ch,
  output logic [SW-1:0]         out_wave
);

  // Product widths: signed sample times a zero-extended (non-negative) gain.
  localparam int PW = SW + EW + 1;
  localparam int QW = SW + VW + 1;

  // Envelope product scaled by 2^-EW, rounded toward zero.
  function automatic logic [SW-1:0] rtz_env(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] sh;
    sh = p >>> EW;
    if (p[PW-1] && (|p[EW-1:0])) begin
      sh = sh + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      sh = sh;
    end
    return SW'(sh);
  endfunction

  // Volume product scaled by 2^-VW, rounded toward zero.
  function automatic logic [SW-1:0] rtz_vol(input logic signed [QW-1:0] q);
    logic signed [QW-1:0] sh;
    sh = q >>> VW;
    if (q[QW-1] && (|q[VW-1:0])) begin
      sh = sh + {{(QW-1){1'b0}}, 1'b1};
    end else begin
      sh = sh;
    end
    return SW'(sh);
  endfunction

  // Per-channel ramp state (only meaningful when RAMP_EN != 0).
  logic [VW-1:0]  cur_vol_q [NCH];
  logic [VW-1:0]  cur_vol_d [NCH];
  logic [VW-1:0]  vol_sel_s;

  // S0 capture registers.
  logic           s0_valid_q, s0_valid_d;
  logic [CHW-1:0] s0_ch_q, s0_ch_d;
  logic [SW-1:0]  s0_wave_q, s0_wave_d;
  logic [EW:0]    s0_env_q, s0_env_d;
  logic [VW-1:0]  s0_vol_q, s0_vol_d;

  // S1 envelope-stage registers.
  logic           s1_valid_q, s1_valid_d;
  logic [CHW-1:0] s1_ch_q, s1_ch_d;
  logic [SW-1:0]  s1_e_q, s1_e_d;
  logic [VW-1:0]  s1_vol_q, s1_vol_d;

  // S2 output registers.
  logic           out_valid_q, out_valid_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0]  out_wave_q, out_wave_d;

  logic signed [PW-1:0] prod_env_s;
  logic signed [QW-1:0] prod_vol_s;

  // Volume select for the incoming channel and next ramp state; out-of-range channels match nothing.
  always_comb begin
    vol_sel_s = {VW{1'b0}};
    cur_vol_d = cur_vol_q;
    for (int c = 0; c < NCH; c++) begin
      if (in_ch == CHW'(c)) begin
        if (RAMP_EN != 0) begin
          vol_sel_s = cur_vol_q[c];
          if (in_valid) begin
            if (cur_vol_q[c] < reg_volume[c*VW +: VW]) begin
              cur_vol_d[c] = cur_vol_q[c] + {{(VW-1){1'b0}}, 1'b1};
            end else if (cur_vol_q[c] > reg_volume[c*VW +: VW]) begin
              cur_vol_d[c] = cur_vol_q[c] - {{(VW-1){1'b0}}, 1'b1};
            end else begin
              cur_vol_d[c] = cur_vol_q[c];
            end
          end else begin
            cur_vol_d[c] = cur_vol_q[c];
          end
        end else begin
          vol_sel_s = reg_volume[c*VW +: VW];
        end
      end else begin
        cur_vol_d[c] = cur_vol_q[c];
      end
    end
  end

  // S0 next state: valid always tracks input, data loads only on a valid sample.
  always_comb begin
    s0_valid_d = in_valid;
    s0_ch_d    = s0_ch_q;
    s0_wave_d  = s0_wave_q;
    s0_env_d   = s0_env_q;
    s0_vol_d   = s0_vol_q;
    if (in_valid) begin
      s0_ch_d   = in_ch;
      s0_wave_d = in_wave;
      s0_env_d  = in_envelope;
      s0_vol_d  = vol_sel_s;
    end else begin
      s0_ch_d   = s0_ch_q;
    end
  end

  // S1 next state: envelope gain, bypassed when the envelope MSB is set.
  always_comb begin
    prod_env_s = PW'($signed(s0_wave_q)) * PW'($signed({1'b0, s0_env_q[EW-1:0]}));
    s1_valid_d = s0_valid_q;
    s1_ch_d    = s1_ch_q;
    s1_e_d     = s1_e_q;
    s1_vol_d   = s1_vol_q;
    if (s0_valid_q) begin
      s1_ch_d  = s0_ch_q;
      s1_vol_d = s0_vol_q;
      if (s0_env_q[EW]) begin
        s1_e_d = s0_wave_q;
      end else begin
        s1_e_d = rtz_env(prod_env_s);
      end
    end else begin
      s1_ch_d = s1_ch_q;
    end
  end

  // S2 next state: channel volume gain; full scale is (2^VW-1)/2^VW, never unity.
  always_comb begin
    prod_vol_s  = QW'($signed(s1_e_q)) * QW'($signed({1'b0, s1_vol_q}));
    out_valid_d = s1_valid_q;
    out_ch_d    = out_ch_q;
    out_wave_d  = out_wave_q;
    if (s1_valid_q) begin
      out_ch_d   = s1_ch_q;
      out_wave_d = rtz_vol(prod_vol_s);
    end else begin
      out_ch_d   = out_ch_q;
    end
  end

  // Pipeline and ramp state registers; reset discards in-flight samples and ramps.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int c = 0; c < NCH; c++) begin
        cur_vol_q[c] <= {VW{1'b0}};
      end
      s0_valid_q  <= 1'b0;
      s0_ch_q     <= {CHW{1'b0}};
      s0_wave_q   <= {SW{1'b0}};
      s0_env_q    <= {(EW+1){1'b0}};
      s0_vol_q    <= {VW{1'b0}};
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= {CHW{1'b0}};
      s1_e_q      <= {SW{1'b0}};
      s1_vol_q    <= {VW{1'b0}};
      out_valid_q <= 1'b0;
      out_ch_q    <= {CHW{1'b0}};
      out_wave_q  <= {SW{1'b0}};
    end else begin
      cur_vol_q   <= cur_vol_d;
      s0_valid_q  <= s0_valid_d;
      s0_ch_q     <= s0_ch_d;
      s0_wave_q   <= s0_wave_d;
      s0_env_q    <= s0_env_d;
      s0_vol_q    <= s0_vol_d;
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_e_q      <= s1_e_d;
      s1_vol_q    <= s1_vol_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_wave_q  <= out_wave_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_wave  = out_wave_q;

endmodule

// File: tb/tb_wts_channel_amp.sv
// Bench for wts_channel_amp: one immediate-volume and one ramping instance
// share the same stimulus; expectations come from an arithmetic model.
module tb_wts_channel_amp;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_ch = 3'd0;
  logic [7:0]  in_wave = 8'd0;
  logic [8:0]  in_envelope = 9'd0;
  logic [19:0] reg_volume = 20'd0;

  logic               ov0, ov1;
  logic [2:0]         oc0, oc1;
  logic signed [7:0]  ow0, ow1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int ch; int wave; int cyc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int last0 = 0;
  int last1 = 0;
  int cur[5];

  wts_channel_amp #(.SW(8), .EW(8), .VW(4), .NCH(5), .RAMP_EN(0)) u_imm (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ch(in_ch),
    .in_wave(in_wave), .in_envelope(in_envelope), .reg_volume(reg_volume),
    .out_valid(ov0), .out_ch(oc0), .out_wave(ow0)
  );

  wts_channel_amp #(.SW(8), .EW(8), .VW(4), .NCH(5), .RAMP_EN(1)) u_ramp (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ch(in_ch),
    .in_wave(in_wave), .in_envelope(in_envelope), .reg_volume(reg_volume),
    .out_valid(ov1), .out_ch(oc1), .out_wave(ow1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Envelope then volume, each scaled and truncated toward zero.
  function automatic int model_out(input int w, input int env, input int vol);
    int e;
    if (env >= 256) e = w;
    else e = (w * (env % 256)) / 256;
    return (e * vol) / 16;
  endfunction

  task automatic send(input bit v, input int ch, input int w, input int env, input logic [19:0] vols);
    exp_t e0, e1;
    int tgt;
    int va_r;
    @(posedge clk); #1;
    in_valid = v;
    in_ch = 3'(ch);
    in_wave = 8'(w);
    in_envelope = 9'(env);
    reg_volume = vols;
    if (v) begin
      tgt = (ch < 5) ? int'((vols >> (ch * 4)) & 20'hF) : 0;
      va_r = (ch < 5) ? cur[ch] : 0;
      if (ch < 5) begin
        if (cur[ch] < tgt) cur[ch]++;
        else if (cur[ch] > tgt) cur[ch]--;
      end
      e0.ch = ch; e0.cyc = cyc; e0.wave = model_out(w, env, tgt);
      e1.ch = ch; e1.cyc = cyc; e1.wave = model_out(w, env, va_r);
      q0.push_back(e0);
      q1.push_back(e1);
    end
  endtask

  task automatic idle();
    send(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128,
         int'($urandom_range(0, 511)), 20'($urandom()));
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_imm_valid", int'(ov0), 0);
    chk("rst_imm_ch", int'(oc0), 0);
    chk("rst_imm_wave", int'(ow0), 0);
    chk("rst_ramp_valid", int'(ov1), 0);
    chk("rst_ramp_ch", int'(oc1), 0);
    chk("rst_ramp_wave", int'(ow1), 0);
    q0.delete();
    q1.delete();
    last0 = 0;
    last1 = 0;
    foreach (cur[i]) cur[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  task automatic mon(input int idx, input logic v, input logic [2:0] ch, input logic signed [7:0] w);
    exp_t e;
    bit have;
    int lw;
    lw = (idx == 0) ? last0 : last1;
    if (v) begin
      have = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        chk($sformatf("u%0d_unexpected_out", idx), int'(w), 9999);
      end else begin
        if (idx == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("u%0d_ch", idx), int'(ch), e.ch);
        chk($sformatf("u%0d_wave", idx), int'(w), e.wave);
        chk($sformatf("u%0d_latency", idx), cyc, e.cyc + 3);
      end
      if (idx == 0) last0 = int'(w);
      else last1 = int'(w);
    end else begin
      chk($sformatf("u%0d_hold", idx), int'(w), lw);
    end
  endtask

  // Output monitor: compares every presented result against the scoreboard.
  always @(negedge clk) begin
    if (nreset) begin
      mon(0, ov0, oc0, ow0);
      mon(1, ov1, oc1, ow1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [19:0] vols;
    foreach (cur[i]) cur[i] = 0;
    apply_reset();
    idle();

    // Bypass envelope at near-full volume, then rounding cases.
    send(1'b1, 0, -128, 9'h100, 20'hFFFFF);
    send(1'b1, 0, -1, 9'h001, 20'hFFFFF);
    send(1'b1, 0, 127, 9'h080, 20'h88888);
    idle();
    idle();

    // Back-to-back channels 0..4.
    send(1'b1, 0, 10, 9'h100, 20'hFFFFF);
    send(1'b1, 1, -20, 9'h100, 20'hFFFFF);
    send(1'b1, 2, 30, 9'h100, 20'hFFFFF);
    send(1'b1, 3, -40, 9'h100, 20'hFFFFF);
    send(1'b1, 4, 127, 9'h100, 20'hFFFFF);

    // Out-of-range channel.
    send(1'b1, 7, 100, 9'h100, 20'hFFFFF);
    repeat (4) idle();

    // Ramp from a clean reset: up to 15, then down to 3; ch1 never sampled.
    apply_reset();
    for (int i = 0; i < 20; i++) send(1'b1, 0, 16, 9'h100, 20'h0009F);
    for (int i = 0; i < 16; i++) send(1'b1, 0, 16, 9'h100, 20'h00093);
    send(1'b1, 1, 16, 9'h100, 20'h0009F);
    repeat (4) idle();

    // Reset with three samples in flight.
    send(1'b1, 0, 50, 9'h100, 20'hFFFFF);
    send(1'b1, 1, -60, 9'h100, 20'hFFFFF);
    send(1'b1, 2, 70, 9'h100, 20'hFFFFF);
    idle();
    apply_reset();
    repeat (4) idle();
    send(1'b1, 0, 64, 9'h100, 20'hFFFFF);
    send(1'b1, 0, 64, 9'h100, 20'hFFFFF);
    repeat (4) idle();

    // Randomized traffic with occasional volume target changes.
    vols = 20'($urandom());
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) vols = 20'($urandom());
      send(bit'($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 511)), vols);
    end

    repeat (8) idle();
    chk("imm_drained", q0.size(), 0);
    chk("ramp_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wts_channel_amp.md
# wts_channel_amp

Time-multiplexed, parametrised channel amplifier for the wave table sound engine. It applies a per-sample envelope gain, then a per-channel volume gain, to a stream of signed wave samples tagged with a channel index. It sits between the wave SRAM readout and the mixer. Compared with the earlier fixed 8-bit single-channel volume stage, it adds:
- one shared pipeline for N channels;
- generic sample, envelope and volume widths;
- a valid-tagged data path;
- optional per-channel volume ramping (de-zipper), which removes clicks on volume changes.

## Interface
Parameters:
- SW, 8, signed sample width (in and out)
- EW, 8, envelope fraction width; envelope port is EW+1 bits
- VW, 4, volume width per channel
- NCH, 5, channel count; CHW = max(1, clog2(NCH)) is derived, not overridable
- RAMP_EN, 1, 1 = current volume steps toward target by 1 per processed sample of that channel; 0 = target applied immediately

Ports:
- clk  in  1  clock, all state on rising edge
- nreset  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample present this cycle
- in_ch  in  CHW  channel of the sample
- in_wave  in  SW  signed sample
- in_envelope  in  EW+1  MSB=1 means unity (bypass); otherwise gain = in_envelope[EW-1:0] / 2^EW
- reg_volume  in  NCH*VW  packed target volumes; channel c is at [c*VW +: VW]; gain = v / 2^VW
- out_valid  out  1  result present
- out_ch  out  CHW  channel tag of the result
- out_wave  out  SW  signed result

## Operation
- Three register stages, S0, S1 and S2. Every stage accepts a new sample every cycle and is never stalled. There is no ready signal; the upstream block must tolerate an accept-always sink.
- **S0 (capture):**
  - Registers in_valid, in_ch, in_wave and in_envelope.
  - Registers the applied volume vol_a: cur_vol[in_ch] when RAMP_EN=1, or the reg_volume field for in_ch when RAMP_EN=0.
  - in_ch >= NCH: vol_a = 0 and no ramp state changes.
- **S1 (envelope):**
  - If the envelope MSB is set: e = wave.
  - Otherwise: p = wave × {0, env[EW-1:0]} as a signed SW+EW+1-bit product, and e = p >>> EW rounded toward zero. That is, if p < 0 and p[EW-1:0] != 0, add 1 to the arithmetic-shifted value.
  - e is always SW bits; |e| <= |wave|, so no overflow is possible.
- **S2 (volume):**
  - q = e × {0, vol_a} as a signed product, then q >>> VW rounded toward zero using the same rule.
  - The result is registered to out_wave. Maximum volume (2^VW−1) gives e×(2^VW−1)/2^VW, never unity.
- **Ramp** (RAMP_EN=1), per-channel register cur_vol[c] of VW bits:
  - Updated only on the edge where in_valid=1 and in_ch=c<NCH.
  - cur_vol < target: increment by 1. cur_vol > target: decrement by 1. Equal: hold.
  - The update happens on the same edge as capture, so the captured vol_a is the pre-update value.
  - Back-to-back samples on one channel therefore see consecutive volumes.
  - Target changes mid-ramp take effect from the next sample, and direction may reverse.
  - Channels that receive no samples do not ramp.
- **Validity:** out_valid and out_ch follow in_valid and in_ch through the pipeline. Data registers update only when their stage's valid is 1; otherwise they hold their value, and out_wave holds its last value while out_valid=0.

## Timing
- Latency is 3 cycles: a sample presented with in_valid=1 at edge k appears with out_valid=1 after edge k+3.
- Throughput is 1 sample per cycle, with any channel order, including the same channel repeated.
- Reset (nreset=0, asynchronous, allowed mid-stream):
  - all stage valids, out_valid and out_ch go to 0;
  - out_wave = 0;
  - all cur_vol = 0;
  - in-flight samples are discarded, with no output emitted for them.
- After reset is released, the first output is valid no earlier than 3 edges after the first accepted in_valid.
- reg_volume is sampled only at S0 capture. Changes take effect for the next captured sample on that channel.

## Test plan
- RAMP_EN=0, SW=8, EW=8, VW=4; ch0 wave=−128, env=0x100 (bypass), vol=15 → out_wave=−120 (0x88), out_ch=0, out_valid exactly 3 cycles after in_valid.
- Rounding toward zero: wave=−1, env=0x001, vol=15 → 0. Also wave=127, env=0x080, vol=8 → 63 after S1, then 31 out.
- Throughput: 5 consecutive cycles with ch 0..4 and distinct waves, env=0x100, vol=15 → 5 consecutive out_valid cycles in the same order with matching out_ch and correct values.
- Ramp: RAMP_EN=1 after reset, target ch0=15, ch0 wave=16 with env bypass every cycle → outputs 0,1,2,…,15,15,…. Changing the target to 3 after output 10 → outputs step down by 1 to 3 and hold. ch1 cur_vol stays 0 throughout.
- Out-of-range channel: in_ch=7 (NCH=5), wave=100 → out_valid=1, out_ch=7, out_wave=0; no cur_vol changes.
- Reset mid-stream: assert nreset=0 with 3 samples in flight → out_valid=0 and out_wave=0 immediately. After release, none of those samples is output, and ramps restart from 0.
